// File: rtl/qos_pkg.sv
// ---------------------------------------------------------------------------
// qos_pkg
// Shared parameter file for the QoS datapath. The translater, the virtual
// channel FIFOs and the arbiter all take their default sizes from here so
// that entry widths, depths and flag thresholds stay in agreement.
//
// Contents:
//   QOS_DATA_WIDTH - width of one translated entry
//   QOS_ADDR_WIDTH - log2 of the FIFO depth
//   QOS_AF_THRESH  - occupancy at or above which almost_full asserts
//   QOS_AE_THRESH  - occupancy at or below which almost_empty asserts
//   qos_depth()    - number of entries for a given address width
// ---------------------------------------------------------------------------
package qos_pkg;

   localparam int QOS_DATA_WIDTH = 6;
   localparam int QOS_ADDR_WIDTH = 2;
   localparam int QOS_AF_THRESH  = 3;
   localparam int QOS_AE_THRESH  = 1;

   // Depth of a FIFO addressed by addr_width pointer bits.
   function automatic int qos_depth(input int addr_width);
      return 1 << addr_width;
   endfunction

endpackage

// File: rtl/fifo_mem.sv
// ---------------------------------------------------------------------------
// fifo_mem
// Storage array for vc_fifo: one write port and one registered read port.
// The array itself carries no reset; only the read register is cleared so
// the FIFO output starts at a known value.
//
// Ports:
//   clk     in   clock, rising edge
//   reset_L in   asynchronous active-low reset (read register only)
//   we      in   write enable
//   waddr   in   write address  [ADDR_WIDTH-1:0]
//   wdata   in   write data     [DATA_WIDTH-1:0]
//   re      in   read enable; rdata loads mem[raddr] on the next edge
//   raddr   in   read address   [ADDR_WIDTH-1:0]
//   rdata   out  registered read data, holds when re=0
// ---------------------------------------------------------------------------
module fifo_mem
   import qos_pkg::*;
#(
   parameter int DATA_WIDTH = QOS_DATA_WIDTH,
   parameter int ADDR_WIDTH = QOS_ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset_L,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic                  re,
   input  logic [ADDR_WIDTH-1:0] raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   localparam int DEPTH = qos_depth(ADDR_WIDTH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   // Write port. No reset on the array: stale contents are never visible
   // because the control logic only reads slots it has written.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Registered read port. A read and a write to the same slot in one cycle
   // returns the old contents, which is what a simultaneous push/pop on a
   // full FIFO needs.
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         rdata <= '0;
      end else if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/vc_fifo.sv
// ---------------------------------------------------------------------------
// vc_fifo
// Virtual-channel FIFO sitting behind the translater stage. Holds up to
// 2**ADDR_WIDTH entries, returns the head entry one cycle after an accepted
// pop, and exposes occupancy and threshold flags for the arbiter.
//
// Optional feature: define VC_FIFO_ERROR_EN to build the sticky
// overflow/underflow flag. Without it, error is tied low.
//
// Ports:
//   clk          in   clock, rising edge
//   reset_L      in   asynchronous active-low reset
//   push         in   write request for data_in
//   data_in      in   entry to store             [DATA_WIDTH-1:0]
//   pop          in   read request
//   data_out     out  registered head entry      [DATA_WIDTH-1:0]
//   valid_out    out  data_out valid this cycle
//   full         out  occupancy == depth
//   empty        out  occupancy == 0
//   almost_full  out  occupancy >= AF_THRESH
//   almost_empty out  occupancy <= AE_THRESH
//   fifo_count   out  current occupancy          [ADDR_WIDTH:0]
//   error        out  sticky overflow/underflow flag
// ---------------------------------------------------------------------------
module vc_fifo
   import qos_pkg::*;
#(
   parameter int DATA_WIDTH = QOS_DATA_WIDTH,
   parameter int ADDR_WIDTH = QOS_ADDR_WIDTH,
   parameter int AF_THRESH  = QOS_AF_THRESH,
   parameter int AE_THRESH  = QOS_AE_THRESH
) (
   input  logic                  clk,
   input  logic                  reset_L,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  pop,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  valid_out,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic [ADDR_WIDTH:0]   fifo_count,
   output logic                  error
);

   localparam logic [ADDR_WIDTH:0] DEPTH_LVL = (ADDR_WIDTH+1)'(qos_depth(ADDR_WIDTH));
   localparam logic [ADDR_WIDTH:0] AF_LVL    = (ADDR_WIDTH+1)'(AF_THRESH);
   localparam logic [ADDR_WIDTH:0] AE_LVL    = (ADDR_WIDTH+1)'(AE_THRESH);

   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [ADDR_WIDTH-1:0] rd_ptr;
   logic [ADDR_WIDTH:0]   count;
   logic                  do_push;
   logic                  do_pop;

   // Accept decisions. A pop needs something stored; a push needs a free
   // slot, or a slot being freed by a pop in the same cycle. A pop on an
   // empty FIFO is ignored even when a push arrives alongside it, so the
   // freshly pushed entry is never read in the cycle it is written.
   always_comb begin
      do_pop  = pop && !empty;
      do_push = push && (!full || do_pop);
   end

   // Pointer and occupancy registers. Pointers wrap naturally at depth
   // because they are exactly ADDR_WIDTH bits wide.
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
         end
         if (do_push && !do_pop) begin
            count <= count + (ADDR_WIDTH+1)'(1);
         end else if (do_pop && !do_push) begin
            count <= count - (ADDR_WIDTH+1)'(1);
         end
      end
   end

   // valid_out follows an accepted pop by exactly one cycle, lining up with
   // the registered read data.
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         valid_out <= 1'b0;
      end else begin
         valid_out <= do_pop;
      end
   end

   // Flags come straight from the registered count so they change in the
   // same cycle as fifo_count.
   always_comb begin
      fifo_count   = count;
      full         = (count == DEPTH_LVL);
      empty        = (count == '0);
      almost_full  = (count >= AF_LVL);
      almost_empty = (count <= AE_LVL);
   end

`ifdef VC_FIFO_ERROR_EN
   logic error_q;

   // Sticky error: overflow is a push into a full FIFO with no pop to make
   // room; underflow is any pop while empty, with or without a push.
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         error_q <= 1'b0;
      end else if ((push && full && !pop) || (pop && empty)) begin
         error_q <= 1'b1;
      end
   end

   assign error = error_q;
`else
   assign error = 1'b0;
`endif

   fifo_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_mem (
      .clk     (clk),
      .reset_L (reset_L),
      .we      (do_push),
      .waddr   (wr_ptr),
      .wdata   (data_in),
      .re      (do_pop),
      .raddr   (rd_ptr),
      .rdata   (data_out)
   );

endmodule

// File: tb/tb_vc_fifo.sv
// ---------------------------------------------------------------------------
// tb_vc_fifo
// Directed self-checking bench for vc_fifo with default parameters
// (6-bit entries, depth 4, almost_full at 3, almost_empty at 1).
// Expected error values follow VC_FIFO_ERROR_EN when it is defined.
// ---------------------------------------------------------------------------
module tb_vc_fifo;

`ifdef VC_FIFO_ERROR_EN
   localparam logic ERR_EN = 1'b1;
`else
   localparam logic ERR_EN = 1'b0;
`endif

   logic       clk;
   logic       reset_L;
   logic       push;
   logic [5:0] data_in;
   logic       pop;
   logic [5:0] data_out;
   logic       valid_out;
   logic       full;
   logic       empty;
   logic       almost_full;
   logic       almost_empty;
   logic [2:0] fifo_count;
   logic       error;

   int num_checks;
   int num_fails;

   vc_fifo dut (
      .clk          (clk),
      .reset_L      (reset_L),
      .push         (push),
      .data_in      (data_in),
      .pop          (pop),
      .data_out     (data_out),
      .valid_out    (valid_out),
      .full         (full),
      .empty        (empty),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .fifo_count   (fifo_count),
      .error        (error)
   );

   // 10 ns free-running clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      num_checks++;
      if (observed !== expected) begin
         num_fails++;
         $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
      end
   endtask

   // Occupancy and all four flags against hand-computed values.
   task automatic checkFlags(input string tag, input logic [2:0] cnt, input logic f,
                             input logic e, input logic af, input logic ae);
      checkOutput({tag, " count"}, fifo_count, cnt);
      checkOutput({tag, " full"}, full, f);
      checkOutput({tag, " empty"}, empty, e);
      checkOutput({tag, " almost_full"}, almost_full, af);
      checkOutput({tag, " almost_empty"}, almost_empty, ae);
   endtask

   // Drive one cycle of push/pop, let the edge happen, then sample 1 ns later
   // with the request lines already returned to idle.
   task automatic applyStimulus(input logic p, input logic [5:0] d, input logic q);
      push    = p;
      data_in = d;
      pop     = q;
      @(posedge clk);
      #1;
      push = 1'b0;
      pop  = 1'b0;
   endtask

   // Hold reset for two edges and release just after a rising edge.
   task automatic doReset();
      reset_L = 1'b0;
      push    = 1'b0;
      pop     = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset_L = 1'b1;
   endtask

   task automatic checkResetState(input string tag);
      checkFlags(tag, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1);
      checkOutput({tag, " valid_out"}, valid_out, 1'b0);
      checkOutput({tag, " data_out"}, data_out, 6'h00);
      checkOutput({tag, " error"}, error, 1'b0);
   endtask

   initial begin
      num_checks = 0;
      num_fails  = 0;
      reset_L    = 1'b0;
      push       = 1'b0;
      pop        = 1'b0;
      data_in    = '0;

      // Reset values
      doReset();
      checkResetState("reset");

      // Fill with 01..04
      applyStimulus(1'b1, 6'h01, 1'b0);
      checkFlags("push1", 3'd1, 1'b0, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b1, 6'h02, 1'b0);
      checkFlags("push2", 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 6'h03, 1'b0);
      checkFlags("push3", 3'd3, 1'b0, 1'b0, 1'b1, 1'b0);
      applyStimulus(1'b1, 6'h04, 1'b0);
      checkFlags("push4", 3'd4, 1'b1, 1'b0, 1'b1, 1'b0);
      checkOutput("push4 error", error, 1'b0);

      // Overflow: 3F is dropped
      applyStimulus(1'b1, 6'h3F, 1'b0);
      checkFlags("overflow", 3'd4, 1'b1, 1'b0, 1'b1, 1'b0);
      checkOutput("overflow error", error, ERR_EN);
      checkOutput("overflow valid_out", valid_out, 1'b0);

      // Drain: 01..04 each one cycle after its pop
      applyStimulus(1'b0, 6'h00, 1'b1);
      checkOutput("pop1 valid_out", valid_out, 1'b1);
      checkOutput("pop1 data_out", data_out, 6'h01);
      checkFlags("pop1", 3'd3, 1'b0, 1'b0, 1'b1, 1'b0);
      applyStimulus(1'b0, 6'h00, 1'b1);
      checkOutput("pop2 valid_out", valid_out, 1'b1);
      checkOutput("pop2 data_out", data_out, 6'h02);
      applyStimulus(1'b0, 6'h00, 1'b1);
      checkOutput("pop3 valid_out", valid_out, 1'b1);
      checkOutput("pop3 data_out", data_out, 6'h03);
      checkFlags("pop3", 3'd1, 1'b0, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b0, 6'h00, 1'b1);
      checkOutput("pop4 valid_out", valid_out, 1'b1);
      checkOutput("pop4 data_out", data_out, 6'h04);
      checkFlags("pop4", 3'd0, 1'b0, 1'b1, 1'b0, 1'b1);

      // Idle: valid drops, data holds
      applyStimulus(1'b0, 6'h00, 1'b0);
      checkOutput("idle valid_out", valid_out, 1'b0);
      checkOutput("idle data_out", data_out, 6'h04);
      checkOutput("idle error sticky", error, ERR_EN);

      // Simultaneous push/pop at partial and full occupancy
      doReset();
      applyStimulus(1'b1, 6'h10, 1'b0);
      applyStimulus(1'b1, 6'h11, 1'b0);
      applyStimulus(1'b1, 6'h2A, 1'b1);
      checkOutput("mid pushpop valid_out", valid_out, 1'b1);
      checkOutput("mid pushpop data_out", data_out, 6'h10);
      checkFlags("mid pushpop", 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 6'h2B, 1'b0);
      applyStimulus(1'b1, 6'h2C, 1'b0);
      checkFlags("refill", 3'd4, 1'b1, 1'b0, 1'b1, 1'b0);
      applyStimulus(1'b1, 6'h2D, 1'b1);
      checkOutput("full pushpop data_out", data_out, 6'h11);
      checkFlags("full pushpop", 3'd4, 1'b1, 1'b0, 1'b1, 1'b0);
      checkOutput("full pushpop error", error, 1'b0);
      applyStimulus(1'b0, 6'h00, 1'b1);
      checkOutput("drainA data_out", data_out, 6'h2A);
      applyStimulus(1'b0, 6'h00, 1'b1);
      checkOutput("drainB data_out", data_out, 6'h2B);
      applyStimulus(1'b0, 6'h00, 1'b1);
      checkOutput("drainC data_out", data_out, 6'h2C);
      applyStimulus(1'b0, 6'h00, 1'b1);
      checkOutput("drainD data_out", data_out, 6'h2D);
      checkOutput("drainD valid_out", valid_out, 1'b1);
      checkFlags("drainD", 3'd0, 1'b0, 1'b1, 1'b0, 1'b1);
      checkOutput("drainD error", error, 1'b0);

      // Underflow, then push+pop while empty
      applyStimulus(1'b0, 6'h00, 1'b1);
      checkOutput("underflow valid_out", valid_out, 1'b0);
      checkOutput("underflow error", error, ERR_EN);
      checkFlags("underflow", 3'd0, 1'b0, 1'b1, 1'b0, 1'b1);
      applyStimulus(1'b1, 6'h07, 1'b1);
      checkOutput("empty pushpop valid_out", valid_out, 1'b0);
      checkFlags("empty pushpop", 3'd1, 1'b0, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b0, 6'h00, 1'b1);
      checkOutput("empty pushpop follow data_out", data_out, 6'h07);
      checkOutput("empty pushpop follow valid_out", valid_out, 1'b1);

      // Asynchronous reset with three entries stored
      doReset();
      applyStimulus(1'b1, 6'h21, 1'b0);
      applyStimulus(1'b1, 6'h22, 1'b0);
      applyStimulus(1'b1, 6'h23, 1'b0);
      applyStimulus(1'b1, 6'h24, 1'b1);
      checkOutput("prereset data_out", data_out, 6'h21);
      checkFlags("prereset", 3'd3, 1'b0, 1'b0, 1'b1, 1'b0);
      #2;
      reset_L = 1'b0;
      #1;
      checkResetState("async reset");
      @(posedge clk);
      #1;
      reset_L = 1'b1;
      applyStimulus(1'b1, 6'h05, 1'b0);
      checkFlags("post reset push", 3'd1, 1'b0, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b0, 6'h00, 1'b1);
      checkOutput("post reset data_out", data_out, 6'h05);
      checkOutput("post reset valid_out", valid_out, 1'b1);
      checkFlags("post reset pop", 3'd0, 1'b0, 1'b1, 1'b0, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
      $finish;
   end

endmodule
